// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: frontend FSM states, AHB encodings and APB slave address windows.
package ahb_apb_pkg;
   typedef enum logic [2:0] {IDLE, WDATA, XFER, RDWAIT, ERR1, ERR2} state_t;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ = 2'b11;
   localparam logic [1:0] HRESP_OKAY = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [31:0] S0_BASE = 32'h8000_0000;
   localparam logic [31:0] S0_LIMIT = 32'h83FF_FFFF;
   localparam logic [31:0] S1_BASE = 32'h8400_0000;
   localparam logic [31:0] S1_LIMIT = 32'h87FF_FFFF;
   localparam logic [31:0] S2_BASE = 32'h8800_0000;
   localparam logic [31:0] S2_LIMIT = 32'h8BFF_FFFF;
   function automatic logic in_window(input logic [31:0] a, input logic [31:0] base, input logic [31:0] limit);
      return a >= base && a <= limit;
   endfunction
endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: maps an AHB address to a one-hot APB slave select and flags bad transfers.
module ahb_addr_decode
   import ahb_apb_pkg::*;
(
   input  logic [31:0] Haddr,
   input  logic [2:0]  Hsize,
   output logic [2:0]  sel,
   output logic        error
);
   assign sel = {in_window(Haddr, S2_BASE, S2_LIMIT),
                 in_window(Haddr, S1_BASE, S1_LIMIT),
                 in_window(Haddr, S0_BASE, S0_LIMIT)};
   // APB slaves are at most 32 bits wide, so wider beats are rejected
   assign error = sel == 3'b000 || Hsize > 3'd2;
endmodule

// File: rtl/ahb_slave_frontend.sv
// ahb_slave_frontend: AHB slave that turns single transfers into one downstream request each,
// stalling the bus until the APB side completes and answering bad transfers with a two-cycle ERROR.
module ahb_slave_frontend
   import ahb_apb_pkg::*;
(
   input  logic        clock,
   input  logic        Hreset,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic        Hwrite,
   input  logic [1:0]  Htrans,
   input  logic [2:0]  Hsize,
   input  logic        Hreadyin,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata,
   output logic        xfer_valid,
   output logic [31:0] xfer_addr,
   output logic [31:0] xfer_wdata,
   output logic        xfer_write,
   output logic [2:0]  xfer_sel,
   input  logic        xfer_ready,
   input  logic        rd_valid,
   input  logic [31:0] rd_data
);
   state_t state, state_nxt;
   logic [2:0] dec_sel;
   logic dec_err, accept;

   ahb_addr_decode u_dec (
      .Haddr(Haddr),
      .Hsize(Hsize),
      .sel(dec_sel),
      .error(dec_err)
   );

   assign accept = state == IDLE && Hreadyin && Htrans != HTRANS_IDLE && Htrans != HTRANS_BUSY;

   always_ff @(posedge clock or posedge Hreset) begin
      if (Hreset) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      Hreadyout = 1'b0;
      Hresp = HRESP_OKAY;
      xfer_valid = 1'b0;
      case (state)
         IDLE: begin
            Hreadyout = 1'b1;
            if (accept) state_nxt = dec_err ? ERR1 : Hwrite ? WDATA : XFER;
         end
         WDATA: state_nxt = XFER;
         XFER: begin
            xfer_valid = 1'b1;
            if (xfer_ready) state_nxt = xfer_write ? IDLE : RDWAIT;
         end
         RDWAIT: if (rd_valid) state_nxt = IDLE;
         ERR1: begin
            Hresp = HRESP_ERROR;
            state_nxt = ERR2;
         end
         ERR2: begin
            Hresp = HRESP_ERROR;
            Hreadyout = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are held from acceptance until the next accepted transfer
   always_ff @(posedge clock or posedge Hreset) begin
      if (Hreset) begin
         xfer_addr <= '0;
         xfer_write <= 1'b0;
         xfer_sel <= '0;
         xfer_wdata <= '0;
         Hrdata <= '0;
      end else begin
         if (accept) begin
            xfer_addr <= Haddr;
            xfer_write <= Hwrite;
            xfer_sel <= dec_sel;
         end
         if (state == WDATA) xfer_wdata <= Hwdata;
         if (state == RDWAIT && rd_valid) Hrdata <= rd_data;
      end
   end
endmodule

// File: tb/tb_ahb_slave_frontend.sv
// tb_ahb_slave_frontend: randomized transfers checked each cycle against a transaction-timeline model.
module tb_ahb_slave_frontend;
   logic clock = 1'b0;
   logic Hreset;
   logic [31:0] Haddr, Hwdata, rd_data;
   logic Hwrite, Hreadyin, xfer_ready, rd_valid;
   logic [1:0] Htrans;
   logic [2:0] Hsize;
   logic Hreadyout, xfer_valid, xfer_write;
   logic [1:0] Hresp;
   logic [31:0] Hrdata, xfer_addr, xfer_wdata;
   logic [2:0] xfer_sel;

   ahb_slave_frontend dut (
      .clock(clock), .Hreset(Hreset),
      .Haddr(Haddr), .Hwdata(Hwdata), .Hwrite(Hwrite), .Htrans(Htrans), .Hsize(Hsize), .Hreadyin(Hreadyin),
      .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
      .xfer_valid(xfer_valid), .xfer_addr(xfer_addr), .xfer_wdata(xfer_wdata), .xfer_write(xfer_write), .xfer_sel(xfer_sel),
      .xfer_ready(xfer_ready), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 clock = ~clock;

   int checks = 0, errors = 0;
   bit chk_en = 1'b0;
   logic exp_ready, exp_valid, exp_write;
   logic [1:0] exp_resp;
   logic [2:0] exp_sel;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;
   logic [31:0] m_rdata = '0, m_wdata = '0;
   int off, first_valid, n_valid, n_err;
   logic [2:0] sel_seen;
   logic write_seen, obs_ready;
   logic [31:0] wdata_seen, obs_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Slave windows are 64 MiB each, starting at 0x8000_0000
   function automatic logic [2:0] ref_sel(input logic [31:0] a);
      longint o = longint'(a) - 64'sh8000_0000;
      if (o < 0 || o >= 3 * 64'sh400_0000) return 3'b000;
      return 3'(1 << int'(o / 64'sh400_0000));
   endfunction

   task automatic set_exp(input logic r, input logic [1:0] resp, input logic v);
      exp_ready = r;
      exp_resp = resp;
      exp_valid = v;
      exp_rdata = m_rdata;
   endtask

   always @(negedge clock) if (chk_en) begin
      chk("hreadyout", 32'(Hreadyout), 32'(exp_ready));
      chk("hresp", 32'(Hresp), 32'(exp_resp));
      chk("xfer_valid", 32'(xfer_valid), 32'(exp_valid));
      chk("hrdata", Hrdata, exp_rdata);
      if (exp_valid) begin
         chk("xfer_addr", xfer_addr, exp_addr);
         chk("xfer_wdata", xfer_wdata, exp_wdata);
         chk("xfer_write", 32'(xfer_write), 32'(exp_write));
         chk("xfer_sel", 32'(xfer_sel), 32'(exp_sel));
      end
   end

   task automatic cycle();
      @(negedge clock);
      if (xfer_valid) begin
         if (first_valid < 0) first_valid = off;
         n_valid++;
         sel_seen = xfer_sel;
         write_seen = xfer_write;
         wdata_seen = xfer_wdata;
      end
      if (Hresp == 2'b01) n_err++;
      obs_ready = Hreadyout;
      obs_rdata = Hrdata;
      @(posedge clock);
      #1;
      off++;
   endtask

   task automatic noise();
      Haddr = $urandom;
      Hwrite = 1'($urandom);
      Htrans = 2'($urandom);
      Hsize = 3'($urandom_range(0, 2));
      Hreadyin = 1'($urandom);
      Hwdata = $urandom;
      xfer_ready = 1'($urandom);
      rd_valid = 1'($urandom);
      rd_data = $urandom;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_hreadyout"}, 32'(Hreadyout), 32'd1);
      chk({tag, "_hresp"}, 32'(Hresp), 32'd0);
      chk({tag, "_hrdata"}, Hrdata, 32'd0);
      chk({tag, "_xfer_valid"}, 32'(xfer_valid), 32'd0);
      chk({tag, "_xfer_addr"}, xfer_addr, 32'd0);
      chk({tag, "_xfer_wdata"}, xfer_wdata, 32'd0);
      chk({tag, "_xfer_write"}, 32'(xfer_write), 32'd0);
      chk({tag, "_xfer_sel"}, 32'(xfer_sel), 32'd0);
   endtask

   task automatic idle_cycle();
      noise();
      Htrans = 2'b00;
      set_exp(1'b1, 2'b00, 1'b0);
      cycle();
   endtask

   // Abandon the read in RDWAIT; the late rd_valid must not complete anything
   task automatic reset_seq();
      Hreset = 1'b1;
      #1;
      reset_checks("mid_rst");
      m_rdata = '0;
      m_wdata = '0;
      Htrans = 2'b00;
      rd_valid = 1'b1;
      xfer_ready = 1'b1;
      set_exp(1'b1, 2'b00, 1'b0);
      @(negedge clock);
      #1;
      Hreset = 1'b0;
      @(posedge clock);
      #1;
      cycle();
   endtask

   task automatic txn(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr, input logic rin,
                      input logic [31:0] wd, input int rw, input int dw, input logic [31:0] rd, input bit rst_mid);
      logic [2:0] s;
      logic err;
      s = ref_sel(a);
      err = s == 3'b000 || sz > 3'd2;
      off = 0; first_valid = -1; n_valid = 0; n_err = 0;
      noise();
      Haddr = a; Hwrite = w; Hsize = sz; Htrans = tr; Hreadyin = rin;
      set_exp(1'b1, 2'b00, 1'b0);
      cycle();
      if (!(rin && tr[1])) return;
      if (err) begin
         noise();
         set_exp(1'b0, 2'b01, 1'b0);
         cycle();
         noise();
         set_exp(1'b1, 2'b01, 1'b0);
         cycle();
         return;
      end
      if (w) begin
         noise();
         Hwdata = wd;
         set_exp(1'b0, 2'b00, 1'b0);
         cycle();
         m_wdata = wd;
      end
      exp_addr = a; exp_wdata = m_wdata; exp_write = w; exp_sel = s;
      for (int i = 0; i <= rw; i++) begin
         noise();
         xfer_ready = i == rw;
         set_exp(1'b0, 2'b00, 1'b1);
         cycle();
      end
      if (w) return;
      for (int i = 0; i <= dw; i++) begin
         noise();
         rd_valid = i == dw;
         rd_data = i == dw ? rd : $urandom;
         set_exp(1'b0, 2'b00, 1'b0);
         cycle();
         if (rst_mid) begin
            reset_seq();
            return;
         end
      end
      m_rdata = rd;
   endtask

   logic [31:0] ra;
   initial begin
      Hreset = 1'b0;
      noise();
      Htrans = 2'b00;
      set_exp(1'b1, 2'b00, 1'b0);
      #1 Hreset = 1'b1;
      #2 reset_checks("rst");
      chk_en = 1'b1;
      repeat (2) @(posedge clock);
      #1 Hreset = 1'b0;
      // Write accepted on the first edge after reset release, xfer_ready always 1
      txn(32'h8000_0010, 1'b1, 3'd2, 2'b10, 1'b1, 32'hDEAD_BEEF, 0, 0, '0, 1'b0);
      chk("wr_first_valid", 32'(first_valid), 32'd2);
      chk("wr_n_valid", 32'(n_valid), 32'd1);
      chk("wr_sel", 32'(sel_seen), 32'b001);
      chk("wr_write", 32'(write_seen), 32'd1);
      chk("wr_wdata", wdata_seen, 32'hDEAD_BEEF);
      idle_cycle();
      chk("wr_ready_after", 32'(obs_ready), 32'd1);
      txn(32'h8400_0004, 1'b0, 3'd2, 2'b10, 1'b1, '0, 0, 2, 32'h1234_5678, 1'b0);
      chk("rd_first_valid", 32'(first_valid), 32'd1);
      chk("rd_sel", 32'(sel_seen), 32'b010);
      idle_cycle();
      chk("rd_hrdata", obs_rdata, 32'h1234_5678);
      chk("rd_ready", 32'(obs_ready), 32'd1);
      txn(32'h9000_0000, 1'b0, 3'd2, 2'b10, 1'b1, '0, 0, 0, '0, 1'b0);
      chk("err_cycles", 32'(n_err), 32'd2);
      chk("err_valid", 32'(n_valid), 32'd0);
      txn(32'h8800_0000, 1'b1, 3'd2, 2'b11, 1'b1, 32'hA5A5_0F0F, 5, 0, '0, 1'b0);
      chk("stall_n_valid", 32'(n_valid), 32'd6);
      chk("stall_wdata", wdata_seen, 32'hA5A5_0F0F);
      txn(32'h8000_0000, 1'b0, 3'd3, 2'b10, 1'b1, '0, 0, 0, '0, 1'b0);
      chk("size_err_cycles", 32'(n_err), 32'd2);
      txn(32'h8BFF_FFFC, 1'b0, 3'd2, 2'b01, 1'b1, '0, 0, 0, '0, 1'b0);
      txn(32'h8BFF_FFFC, 1'b0, 3'd0, 2'b10, 1'b1, '0, 1, 0, 32'h0BAD_F00D, 1'b0);
      txn(32'h8C00_0000, 1'b1, 3'd2, 2'b10, 1'b1, 32'h1, 0, 0, '0, 1'b0);
      txn(32'h7FFF_FFFC, 1'b1, 3'd2, 2'b10, 1'b1, 32'h2, 0, 0, '0, 1'b0);
      txn(32'h8400_0100, 1'b0, 3'd2, 2'b10, 1'b1, '0, 1, 3, 32'hCAFE_0001, 1'b1);
      chk("post_rst_rdata", obs_rdata, 32'd0);
      txn(32'h8400_0008, 1'b0, 3'd1, 2'b10, 1'b1, '0, 0, 1, 32'h5555_AAAA, 1'b0);
      idle_cycle();
      chk("post_rst_read", obs_rdata, 32'h5555_AAAA);
      repeat (250) begin
         case ($urandom_range(0, 4))
            0: ra = 32'h8000_0000 | 32'($urandom_range(0, 32'h03FF_FFFF));
            1: ra = 32'h8400_0000 | 32'($urandom_range(0, 32'h03FF_FFFF));
            2: ra = 32'h8800_0000 | 32'($urandom_range(0, 32'h03FF_FFFF));
            3: ra = 32'h8C00_0000 | 32'($urandom_range(0, 32'h03FF_FFFF));
            default: ra = $urandom;
         endcase
         txn(ra, 1'($urandom), $urandom_range(0, 7) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
             2'($urandom), $urandom_range(0, 5) != 0, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
      end
      idle_cycle();
      idle_cycle();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ahb_slave_frontend.md
AHB_SLAVE_FRONTEND -- requirements
Module: ahb_slave_frontend

Interface
REQ-001 SHALL have ports clock (in, 1, single clock) and Hreset (in, 1, reset, asynchronous, active-high).
REQ-002 SHALL have AHB inputs:
  - Haddr in 32
  - Hwdata in 32
  - Hwrite in 1
  - Htrans in 2
  - Hsize in 3
  - Hreadyin in 1
REQ-003 SHALL have AHB outputs:
  - Hreadyout out 1, slave ready
  - Hresp out 2, 00 OKAY / 01 ERROR
  - Hrdata out 32, read data
REQ-004 SHALL have downstream request outputs to the APB controller:
  - xfer_valid out 1
  - xfer_addr out 32
  - xfer_wdata out 32
  - xfer_write out 1
  - xfer_sel out 3, one-hot slave select
REQ-005 SHALL have downstream inputs: xfer_ready in 1, rd_valid in 1, rd_data in 32.

Function
REQ-006 SHALL accept a transfer when in IDLE, Hreadyin=1 and Htrans is NONSEQ (10) or SEQ (11); IDLE (00) and BUSY (01) SHALL be ignored.
REQ-007 SHALL decode the address map, all other addresses unmapped:
  - 0x8000_0000-0x83FF_FFFF -> xfer_sel=001
  - 0x8400_0000-0x87FF_FFFF -> 010
  - 0x8800_0000-0x8BFF_FFFF -> 100
REQ-008 SHALL treat an unmapped address or Hsize>2 as an error transfer.
REQ-009 SHALL implement states IDLE, WDATA, XFER, RDWAIT, ERR1, ERR2.
REQ-010 SHALL drive Hreadyout=1 only in IDLE and ERR2, 0 in all other states (combinational from state).
REQ-011 IDLE SHALL transition on an accepted transfer, latching Haddr, Hwrite and xfer_sel on that edge:
  - error -> ERR1
  - mapped write -> WDATA
  - mapped read -> XFER
REQ-012 WDATA SHALL capture Hwdata into xfer_wdata and go to XFER after exactly one cycle.
REQ-013 XFER SHALL hold xfer_valid=1 with stable xfer_* outputs until the cycle xfer_ready=1.
REQ-014 On XFER acceptance: write -> IDLE; read -> RDWAIT.
REQ-015 RDWAIT SHALL wait for rd_valid=1, register rd_data into Hrdata and go to IDLE.
REQ-016 Hrdata SHALL hold its value until the next read completes.
REQ-017 ERR1 SHALL drive Hresp=01, Hreadyout=0 and go to ERR2 unconditionally.
REQ-018 ERR2 SHALL drive Hresp=01, Hreadyout=1, go to IDLE, and ignore any transfer presented in ERR2.
REQ-019 Hresp SHALL be 00 in every state except ERR1/ERR2.
REQ-020 Minimum latency SHALL be: write address phase -> xfer_valid 2 cycles; read address phase -> xfer_valid 1 cycle.
REQ-021 A transfer presented in the IDLE cycle that completes a prior data phase SHALL be accepted (back-to-back pipelining).
REQ-022 xfer_ready and rd_valid SHALL be ignored outside XFER and RDWAIT respectively.

Reset
REQ-023 Hreset=1 SHALL asynchronously force the following values:
  - state=IDLE
  - Hreadyout=1, Hresp=00, Hrdata=0
  - xfer_valid=0, xfer_addr=0, xfer_wdata=0, xfer_write=0, xfer_sel=000
REQ-024 Reset mid-transfer SHALL abandon the transfer with no downstream handshake after release.
REQ-025 The first transfer SHALL be accepted on the first clock edge after Hreset deasserts.

Structure
REQ-026 Package ahb_apb_pkg SHALL hold the state enum, HTRANS/HRESP constants and slave base/limit constants.
REQ-027 Address decode SHALL be a combinational sub-module ahb_addr_decode (Haddr, Hsize -> sel, error).

Verification
REQ-028 Write 0x8000_0010 data 0xDEAD_BEEF, xfer_ready tied 1 -> xfer_valid for 1 cycle at address phase +2 with xfer_sel=001, xfer_write=1, Hreadyout back to 1 the next cycle.
REQ-029 Read 0x8400_0004, xfer_ready=1, rd_valid 3 cycles later with rd_data 0x1234_5678 -> Hrdata=0x1234_5678 with Hreadyout=1, xfer_sel=010.
REQ-030 Access 0x9000_0000 -> Hresp=01 for 2 cycles, Hreadyout 0 then 1, xfer_valid never asserted.
REQ-031 xfer_ready held 0 for 5 cycles during write to 0x8800_0000 -> xfer_valid/addr/wdata stable and Hreadyout=0 throughout, completing the cycle after xfer_ready=1.
REQ-032 Hreset asserted in RDWAIT -> all outputs at reset values immediately; next read completes normally.
